window_frame_sequencer: RTL

// - Frame-level controller in front of the 2-D sliding-window generator. Accepts a framed

---
 rtl/window_frame_sequencer_pkg.sv | 26 ++
 rtl/window_frame_sequencer_if.sv | 14 +
 rtl/window_frame_sequencer_pos_counter.sv | 59 +++++
 rtl/window_frame_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/window_frame_sequencer_pkg.sv
// Shared types and width helpers for the window frame sequencer.
// Purely declarative: no logic, no latency, no flow control.
package winseq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      RUN    = 3'd2,
      FLUSH  = 3'd3,
      RESYNC = 3'd4
   } state_t;

   function automatic int half_of(input int win_size);
      return win_size / 2;
   endfunction

   // Row counter must reach IMG_H+HALF-1 while the bottom pad rows are pushed.
   function automatic int row_w(input int img_h, input int win_size);
      return (img_h + win_size / 2 > 1) ? $clog2(img_h + win_size / 2) : 1;
   endfunction

   function automatic int col_w(input int img_w);
      return (img_w > 1) ? $clog2(img_w) : 1;
   endfunction

endpackage

// File: rtl/window_frame_sequencer_if.sv
// Upstream framed pixel stream: valid/ready handshake with sof/eol markers.
// Transfer happens on a cycle where s_valid and s_ready are both high.
interface window_frame_sequencer_if #(
   parameter int DATA_W = 8
) ();
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_pixel;
   logic              s_sof;
   logic              s_eol;

   modport master (output s_valid, output s_pixel, output s_sof, output s_eol, input s_ready);
   modport slave  (input s_valid, input s_pixel, input s_sof, input s_eol, output s_ready);
endinterface

// File: rtl/window_frame_sequencer_pos_counter.sv
// Push-position counter (row, col) with line wrap and end-of-image / end-of-flush flags.
// Flags are combinational from the registered position; advances one step per enabled cycle.
module winseq_pos_counter #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int HALF  = 1,
   parameter int ROW_W = 9,
   parameter int COL_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [ROW_W-1:0] prow_o,
   output logic [COL_W-1:0] pcol_o,
   output logic             col_last_o,
   output logic             last_o,
   output logic             flush_done_o
);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0] FLUSH_ROW = ROW_W'(IMG_H + HALF - 1);

   logic [ROW_W-1:0] prow_q, prow_d;
   logic [COL_W-1:0] pcol_q, pcol_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prow_q <= '0;
         pcol_q <= '0;
      end else begin
         prow_q <= prow_d;
         pcol_q <= pcol_d;
      end
   end

   always_comb begin
      prow_d = prow_q;
      pcol_d = pcol_q;
      if (clr_i) begin
         prow_d = '0;
         pcol_d = '0;
      end else if (en_i) begin
         if (pcol_q == LAST_COL) begin
            pcol_d = '0;
            prow_d = prow_q + 1'b1;
         end else begin
            pcol_d = pcol_q + 1'b1;
         end
      end
   end

   assign prow_o       = prow_q;
   assign pcol_o       = pcol_q;
   assign col_last_o   = (pcol_q == LAST_COL);
   assign last_o       = (prow_q == LAST_ROW) && (pcol_q == LAST_COL);
   assign flush_done_o = (prow_q == FLUSH_ROW) && (pcol_q == LAST_COL);

endmodule

// File: rtl/window_frame_sequencer.sv
// Frame controller ahead of the sliding-window generator: framing check, clear, bottom pad, tags.
// Pushes are combinational under ds_ready; tag lands one cycle after its push. WINSEQ_PERF_EN adds counters.
module window_frame_sequencer
   import winseq_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                IMG_W     = 640,
   parameter int                IMG_H     = 480,
   parameter int                WIN_SIZE  = 3,
   parameter logic [DATA_W-1:0] PAD_VALUE = '0,
   localparam int               HALF      = half_of(WIN_SIZE),
   localparam int               ROW_W     = row_w(IMG_H, WIN_SIZE),
   localparam int               COL_W     = col_w(IMG_W)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   window_frame_sequencer_if.slave   s_if,
   input  logic                      ds_ready,
   output logic                      w_clear,
   output logic                      w_valid,
   output logic [DATA_W-1:0]         w_pixel,
   output logic                      o_valid,
   output logic [ROW_W-1:0]          o_row,
   output logic [COL_W-1:0]          o_col,
   output logic                      o_edge,
   output logic                      o_pad,
   output logic                      o_eof,
   output logic                      err_sync
`ifdef WINSEQ_PERF_EN
   ,
   output logic [31:0]               perf_frames,
   output logic [31:0]               perf_stalls
`endif
);
   localparam logic [COL_W-1:0] HALF_C   = COL_W'(HALF);
   localparam logic [COL_W-1:0] WRAP_C   = COL_W'(IMG_W - HALF);
   localparam logic [COL_W-1:0] EDGE_C   = COL_W'(WIN_SIZE - 1);
   localparam logic [ROW_W-1:0] HALF_R   = ROW_W'(HALF);
   localparam logic [ROW_W-1:0] TAG_ROW  = ROW_W'(WIN_SIZE - 1);
   localparam logic [ROW_W-1:0] PAD_ROW  = ROW_W'(IMG_H);

   state_t           state_q, state_d;
   logic [ROW_W-1:0] prow;
   logic [COL_W-1:0] pcol;
   logic             col_last, last_px, flush_done;
   logic             push, clr, err, frame_err, eof_push, tag_fire;

   logic             tag_vld_q, tag_edge_q, tag_pad_q, tag_eof_q;
   logic [ROW_W-1:0] tag_row_q;
   logic [COL_W-1:0] tag_col_q;

   winseq_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .HALF  (HALF),
      .ROW_W (ROW_W),
      .COL_W (COL_W)
   ) u_pos (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (clr),
      .en_i         (push),
      .prow_o       (prow),
      .pcol_o       (pcol),
      .col_last_o   (col_last),
      .last_o       (last_px),
      .flush_done_o (flush_done)
   );

   assign frame_err = (s_if.s_sof && ((prow != '0) || (pcol != '0))) || (s_if.s_eol != col_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      s_if.s_ready = 1'b0;
      clr         = 1'b0;
      push        = 1'b0;
      err         = 1'b0;
      w_pixel     = '0;
      case (state_q)
         IDLE: begin
            s_if.s_ready = !s_if.s_sof;
            if (s_if.s_valid) begin
               if (s_if.s_sof) state_d = CLEAR;
               else            err     = 1'b1;
            end
         end
         CLEAR: begin
            clr     = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            s_if.s_ready = ds_ready;
            w_pixel      = s_if.s_pixel;
            if (s_if.s_valid && ds_ready) begin
               if (frame_err) begin
                  err     = 1'b1;
                  state_d = RESYNC;
               end else begin
                  push = 1'b1;
                  if (last_px) state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            w_pixel = PAD_VALUE;
            push    = ds_ready;
            if (ds_ready && flush_done) state_d = IDLE;
         end
         RESYNC: begin
            s_if.s_ready = !s_if.s_sof;
            if (s_if.s_valid && s_if.s_sof) state_d = CLEAR;
         end
         default: state_d = IDLE;
      endcase
   end

   assign w_clear  = clr;
   assign w_valid  = push;
   assign err_sync = err;
   assign eof_push = push && (state_q == FLUSH) && flush_done;
   // Windows only exist once WIN_SIZE rows are buffered in the generator.
   assign tag_fire = push && (prow >= TAG_ROW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_q  <= 1'b0;
         tag_edge_q <= 1'b0;
         tag_pad_q  <= 1'b0;
         tag_eof_q  <= 1'b0;
         tag_row_q  <= '0;
         tag_col_q  <= '0;
      end else begin
         tag_vld_q  <= tag_fire;
         tag_edge_q <= tag_fire && (pcol < EDGE_C);
         tag_pad_q  <= tag_fire && (prow >= PAD_ROW);
         tag_eof_q  <= tag_fire && eof_push;
         if (tag_fire) begin
            tag_row_q <= prow - HALF_R;
            tag_col_q <= (pcol >= HALF_C) ? (pcol - HALF_C) : (pcol + WRAP_C);
         end
      end
   end

   assign o_valid = tag_vld_q;
   assign o_row   = tag_row_q;
   assign o_col   = tag_col_q;
   assign o_edge  = tag_edge_q;
   assign o_pad   = tag_pad_q;
   assign o_eof   = tag_eof_q;

`ifdef WINSEQ_PERF_EN
   logic [31:0] perf_frames_q, perf_stalls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_frames_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (tag_eof_q) perf_frames_q <= perf_frames_q + 32'd1;
         if (((state_q == RUN) || (state_q == FLUSH)) && !ds_ready)
            perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_frames = perf_frames_q;
   assign perf_stalls = perf_stalls_q;
`endif

endmodule
